// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and IF/ID handshake signals.
// Latency: n/a (wires only).
// Backpressure: ReadyIn from decode stalls the IF/ID stage.
// Ports: master = fetch unit side, slave = memory/branch/decode side.
// FETCH_PERF_COUNT_EN adds FetchCount/StallCount.
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] Address;
  logic [31:0]         Instruction;
  logic                RedirectEn;
  logic [PC_WIDTH-1:0] RedirectPC;
  logic [31:0]         InstrOut;
  logic [PC_WIDTH-1:0] PCOut;
  logic [PC_WIDTH-1:0] PCPlus4Out;
  logic                ValidOut;
  logic                ReadyIn;
  logic                Halted;
  logic                AlignErr;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0]         FetchCount;
  logic [31:0]         StallCount;
`endif

  modport master (
    output Address, InstrOut, PCOut, PCPlus4Out, ValidOut, Halted, AlignErr,
`ifdef FETCH_PERF_COUNT_EN
    output FetchCount, StallCount,
`endif
    input  Instruction, RedirectEn, RedirectPC, ReadyIn
  );

  modport slave (
    input  Address, InstrOut, PCOut, PCPlus4Out, ValidOut, Halted, AlignErr,
`ifdef FETCH_PERF_COUNT_EN
    input  FetchCount, StallCount,
`endif
    output Instruction, RedirectEn, RedirectPC, ReadyIn
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_pipe_reg.sv
// IF/ID pipeline register: holds one fetched instruction, its PC and PC+4.
// Latency: 1 cycle from load to outputs.
// Backpressure: contents hold while neither load nor flush is asserted.
// Ports: clk/rst_n, load (capture inputs), flush (invalidate, wins over load),
//        instr_in/pc_in in, instr_out/pc_out/pc_plus4_out/valid_out out.
module fetch_pipe_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                flush,
  input  logic [31:0]         instr_in,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_plus4_out,
  output logic                valid_out
);

  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc4_q, pc4_d;
  logic                valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    // Flush only drops the valid bit; stale data is invisible behind it.
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      pc4_d   = pc_in + PC_WIDTH'(WORD_BYTES);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc4_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads a 0-latency imem, feeds decode via IF/ID.
// Latency: 1 cycle fetch-to-IF/ID; first instruction 2 cycles after reset release.
// Backpressure: ValidOut && !ReadyIn freezes PC and IF/ID; redirect overrides.
// Ports: Clk, Rst_n (async active-low), bus (instruction_fetch_unit_if.master).
// Optional macro FETCH_PERF_COUNT_EN: saturating FetchCount/StallCount outputs.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  IMEM_WORDS = 128
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  instruction_fetch_unit_if.master   bus
);

  localparam logic [PC_WIDTH-1:0] PC_LIMIT = PC_WIDTH'(WORD_BYTES * IMEM_WORDS);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                align_err_q, align_err_d;
  logic                valid_out;
  logic                load;
  logic                in_range;
  logic                capture;
  logic                flush;

  assign load     = !valid_out || bus.ReadyIn;
  assign in_range = pc_q < PC_LIMIT;

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      align_err_q <= align_err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (bus.RedirectEn) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   if (load && !in_range) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: PC update, IF/ID control, sticky alignment error
  always_comb begin
    pc_d        = pc_q;
    capture     = 1'b0;
    flush       = 1'b0;
    align_err_d = align_err_q;
    if (bus.RedirectEn) begin
      // Redirect kills the IF/ID entry even if decode is taking it this cycle.
      pc_d  = {bus.RedirectPC[PC_WIDTH-1:2], 2'b00};
      flush = 1'b1;
      if (bus.RedirectPC[1:0] != 2'b00) align_err_d = 1'b1;
    end else if (state_q == FETCH && load) begin
      if (in_range) begin
        capture = 1'b1;
        pc_d    = pc_q + PC_WIDTH'(WORD_BYTES);
      end else begin
        // Past end of program: never expose an aliased memory word.
        flush = 1'b1;
      end
    end
  end

  fetch_pipe_reg #(.PC_WIDTH(PC_WIDTH)) u_if_id (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .load         (capture),
    .flush        (flush),
    .instr_in     (bus.Instruction),
    .pc_in        (pc_q),
    .instr_out    (bus.InstrOut),
    .pc_out       (bus.PCOut),
    .pc_plus4_out (bus.PCPlus4Out),
    .valid_out    (valid_out)
  );

  assign bus.Address  = pc_q;
  assign bus.ValidOut = valid_out;
  assign bus.Halted   = (state_q == HALT);
  assign bus.AlignErr = align_err_q;

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (valid_out && bus.ReadyIn && fetch_cnt_q != 32'hFFFF_FFFF)
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (valid_out && !bus.ReadyIn && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.FetchCount = fetch_cnt_q;
  assign bus.StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory word i holds i*3.
// Latency: n/a. Backpressure: ReadyIn driven by directed vectors.
module tb_instruction_fetch_unit;

  logic Clk;
  logic Rst_n;

  instruction_fetch_unit_if #(.PC_WIDTH(32)) bus ();

  instruction_fetch_unit #(
    .PC_WIDTH   (32),
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (128)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a >> 2) * 32'd3;
  endfunction

  assign bus.Instruction = memword(bus.Address);

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: what decode should see, from the fetch rules alone.
  localparam logic [31:0] END_ADDR = 32'd512;
  int          m_mode  = 0;  // 0 = just out of reset, 1 = fetching, 2 = halted
  logic [31:0] m_pc    = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pcout = 32'h0;
  logic        m_align = 1'b0;
  logic [31:0] m_fc    = 32'h0;
  logic [31:0] m_sc    = 32'h0;

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0;
    m_pcout = 32'h0; m_align = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
  endtask

  always @(negedge Rst_n) model_reset();

  always @(posedge Clk) begin
    if (!Rst_n) begin
      model_reset();
    end else begin
      if (m_valid && bus.ReadyIn && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      if (m_valid && !bus.ReadyIn && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (bus.RedirectEn) begin
        if (bus.RedirectPC % 4 != 0) m_align = 1'b1;
        m_pc    = bus.RedirectPC - (bus.RedirectPC % 4);
        m_valid = 1'b0;
        m_mode  = 1;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1 && (!m_valid || bus.ReadyIn)) begin
        if (m_pc >= END_ADDR) begin
          m_mode  = 2;
          m_valid = 1'b0;
        end else begin
          m_instr = memword(m_pc);
          m_pcout = m_pc;
          m_valid = 1'b1;
          m_pc    = m_pc + 4;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge Clk) begin
    chk("address", bus.Address, m_pc);
    chk("valid", 32'(bus.ValidOut), 32'(m_valid));
    chk("halted", 32'(bus.Halted), (m_mode == 2) ? 32'd1 : 32'd0);
    chk("align_err", 32'(bus.AlignErr), 32'(m_align));
    if (!Rst_n || m_valid) begin
      chk("instr_out", bus.InstrOut, m_instr);
      chk("pc_out", bus.PCOut, m_pcout);
      chk("pc_plus4", bus.PCPlus4Out, Rst_n ? m_pcout + 32'd4 : 32'd0);
    end
`ifdef FETCH_PERF_COUNT_EN
    chk("fetch_count", bus.FetchCount, m_fc);
    chk("stall_count", bus.StallCount, m_sc);
`endif
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.RedirectEn = 1'b1;
    bus.RedirectPC = target;
    step(1);
    bus.RedirectEn = 1'b0;
    bus.RedirectPC = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [23:0] rdy_pat;

  initial begin
    Rst_n          = 1'b0;
    bus.ReadyIn    = 1'b1;
    bus.RedirectEn = 1'b0;
    bus.RedirectPC = 32'h0;
    step(3);
    chk("rst_valid", 32'(bus.ValidOut), 32'd0);
    chk("rst_instr", bus.InstrOut, 32'd0);
    Rst_n = 1'b1;

    // Streaming from reset
    step(2);
    chk("first_valid", 32'(bus.ValidOut), 32'd1);
    chk("first_pc", bus.PCOut, 32'd0);
    chk("first_instr", bus.InstrOut, 32'd0);
    step(1);
    chk("s1_pc", bus.PCOut, 32'd4);
    chk("s1_instr", bus.InstrOut, 32'd3);
    step(1);
    chk("s2_pc", bus.PCOut, 32'd8);
    chk("s2_instr", bus.InstrOut, 32'd6);

    // Stall for three cycles
    bus.ReadyIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_instr", bus.InstrOut, 32'd6);
      chk("stall_addr", bus.Address, 32'd12);
      chk("stall_valid", 32'(bus.ValidOut), 32'd1);
    end
    bus.ReadyIn = 1'b1;
    step(1);
    chk("resume_pc", bus.PCOut, 32'd12);
    chk("resume_instr", bus.InstrOut, 32'd9);

    // Aligned redirect drops the in-flight word
    redirect(32'h40);
    chk("redir_valid", 32'(bus.ValidOut), 32'd0);
    step(1);
    chk("redir_pc", bus.PCOut, 32'h40);
    chk("redir_instr", bus.InstrOut, 32'd48);

    // Misaligned redirect
    redirect(32'h22);
    chk("mis_align", 32'(bus.AlignErr), 32'd1);
    step(1);
    chk("mis_pc", bus.PCOut, 32'h20);
    chk("mis_instr", bus.InstrOut, 32'd24);

    // Mixed backpressure with a redirect in the middle
    rdy_pat = 24'b1011_0011_1000_1101_1110_0101;
    for (int i = 0; i < 24; i++) begin
      bus.ReadyIn = rdy_pat[i];
      if (i == 10) redirect(32'h100);
      else step(1);
    end
    bus.ReadyIn = 1'b1;
    step(1);

    // End of program
    redirect(32'h1FC);
    step(1);
    chk("last_pc", bus.PCOut, 32'h1FC);
    chk("last_instr", bus.InstrOut, 32'd381);
    step(1);
    chk("halt_flag", 32'(bus.Halted), 32'd1);
    chk("halt_valid", 32'(bus.ValidOut), 32'd0);
    chk("halt_addr", bus.Address, 32'h200);
    step(3);
    chk("halt_addr_frozen", bus.Address, 32'h200);
    redirect(32'h0);
    chk("unhalt", 32'(bus.Halted), 32'd0);
    step(1);
    chk("restart_pc", bus.PCOut, 32'd0);
    chk("align_sticky", 32'(bus.AlignErr), 32'd1);
    step(3);

    // Async reset in the middle of a stall
    bus.ReadyIn = 1'b0;
    step(2);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ValidOut), 32'd0);
    chk("arst_instr", bus.InstrOut, 32'd0);
    chk("arst_pc", bus.PCOut, 32'd0);
    chk("arst_pc4", bus.PCPlus4Out, 32'd0);
    chk("arst_align", 32'(bus.AlignErr), 32'd0);
    chk("arst_addr", bus.Address, 32'd0);
    @(negedge Clk);
    step(1);
    bus.ReadyIn = 1'b1;
    Rst_n = 1'b1;
    step(2);
    chk("post_rst_valid", 32'(bus.ValidOut), 32'd1);
    chk("post_rst_pc", bus.PCOut, 32'd0);
    step(2);
    chk("post_rst_pc2", bus.PCOut, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
